host_cmd_master: RTL and testbench
==================================

Name: host_cmd_master

Overview:
Host-side initiator for the system controller's UART command protocol. It accepts one abstract command per handshake and serializes it into the byte frame the controller expects. It drives a UART transmitter and collects the controller's response bytes from a UART receiver. It then returns one assembled result word with valid/error flags, for use in host-side bridges and testbench traffic generation.

Parameters:
data_Width, 8, width of UART bytes and register data
Addr_width, 4, register-file address width; zero-extended to data_Width in frames
TIMEOUT_CYC, 4096, cycles without progress in any wait state before the command is aborted

Ports:
CLK  in  1  system clock
RST  in  1  asynchronous active-high reset
CMD_VLD  in  1  command request
CMD_RDY  out  1  block idle; accepts a command when CMD_VLD&&CMD_RDY
CMD_TYPE  in  2  0=RF write, 1=RF read, 2=ALU with operands, 3=ALU without operands
CMD_ADDR  in  Addr_width  register address
CMD_DATA_A  in  data_Width  write data (type 0) or operand A (type 2)
CMD_DATA_B  in  data_Width  operand B (type 2)
CMD_FUN  in  4  ALU function (types 2,3)
TX_DATA  out  data_Width  byte to UART transmitter
TX_VLD  out  1  one-cycle byte strobe
TX_BUSY  in  1  transmitter busy
RX_DATA  in  data_Width  byte from UART receiver
RX_VLD  in  1  one-cycle received-byte strobe
RSP_DATA  out  2*data_Width  assembled response
RSP_VLD  out  1  one-cycle response strobe
RSP_ERR  out  1  qualifies RSP_VLD; 1 = timeout abort

Behaviour:
- Reset values: CMD_RDY=1, TX_VLD=0, TX_DATA=0, RSP_VLD=0, RSP_ERR=0, RSP_DATA=0. FSM=IDLE, counters=0.
- Accept: in IDLE with CMD_VLD=1, latch all CMD_* fields. CMD_RDY drops the next cycle and stays low until the return to IDLE.
- Frames, in byte order. Address is zero-extended. FUN is placed in the low nibble with the upper bits 0.
  - type0: AA, addr, data
  - type1: BB, addr
  - type2: CC, A, B, fun
  - type3: DD, fun
- Expected response bytes: type0 none, type1 one, types 2 and 3 two (LSB first).
- States: IDLE -> SEND -> WAIT_HI -> WAIT_LO -> (SEND | RECV | DONE) -> IDLE.
- SEND
  - Waits for TX_BUSY=0, then asserts TX_VLD for exactly 1 cycle with TX_DATA = frame[idx].
  - TX_DATA holds its value until the next SEND.
- WAIT_HI: waits for TX_BUSY=1.
- WAIT_LO
  - Waits for TX_BUSY=0, then increments idx.
  - If more bytes remain, go to SEND.
  - Else go to RECV if any response is expected, or DONE if not.
- RECV
  - Each RX_VLD stores RX_DATA. Byte 0 goes to RSP_DATA[7:0], byte 1 to [15:8].
  - Go to DONE when the expected count is reached.
  - Type1 result: RSP_DATA={0,byte}.
- DONE: RSP_VLD=1 and RSP_ERR=0 for 1 cycle, then IDLE. Type0 reports RSP_DATA=0.
- Latency: RSP_VLD fires 1 cycle after the last byte event (last TX_BUSY fall, or last RX_VLD).
- RSP_DATA holds its value until the next command completes.
- RX_VLD outside RECV is ignored; stray bytes are dropped. This includes a byte arriving in the same cycle as the final TX_BUSY fall.
- Timeout
  - The counter clears on every state change and on every RX_VLD.
  - It increments in SEND, WAIT_HI, WAIT_LO and RECV.
  - On reaching TIMEOUT_CYC-1: RSP_VLD=1, RSP_ERR=1, RSP_DATA=0, then IDLE.
  - The counter saturates and never wraps.
- CMD_VLD while busy is ignored; the requester must hold it until CMD_RDY.
- RST asserted mid-frame aborts immediately with reset values; no response is issued.

Decomposition:
- Shared package holds:
  - frame opcodes CMD_RF_WR=8'hAA, CMD_RF_RD=8'hBB, CMD_ALU_OP=8'hCC, CMD_ALU_NOP=8'hDD
  - CMD_TYPE encodings
  - FSM state enum
  - per-type frame-length and response-length constants
- One sub-module, host_cmd_frame_builder: combinational mux from latched fields and idx to frame byte, frame length and response count. FSM, timeout counter and response assembly stay in the top.

Test Plan:
- RF write type0 addr=5 data=3C, TX_BUSY pulses 10 cycles per byte -> TX bytes AA,05,3C; RSP_VLD with RSP_ERR=0 and RSP_DATA=0000; no RX needed.
- RF read type1 addr=2, model returns RX 7E -> TX BB,02; RSP_DATA=007E one cycle after RX_VLD.
- ALU type2 A=12 B=34 fun=1, RX 46 then 00 -> TX CC,12,34,01; RSP_DATA=0046.
- ALU type3 fun=2 with RX D8,01 -> TX DD,02; RSP_DATA=01D8. Same run: stray RX_VLD AB injected during WAIT_HI is ignored.
- Timeout: TIMEOUT_CYC=64, type1 with no RX -> RSP_VLD with RSP_ERR=1 and RSP_DATA=0000 exactly 64 cycles into RECV; CMD_RDY=1 the next cycle.
- RST asserted after the 2nd TX byte of a type2 command -> all outputs reset immediately, CMD_RDY=1, no RSP_VLD; a following type1 completes normally.

Source files
------------

// File: rtl/host_cmd_master_pkg.sv
// rtl/host_cmd_master_pkg.sv - shared opcodes, command encodings, FSM states and frame sizes
//
// Purpose: common definitions for host_cmd_master and its frame builder.
// Ports: none (package).

package host_cmd_master_pkg;

  // Leading opcode byte of each frame
  localparam logic [7:0] CMD_RF_WR   = 8'hAA;
  localparam logic [7:0] CMD_RF_RD   = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

  // CMD_TYPE encodings
  localparam logic [1:0] TYPE_RF_WR   = 2'd0;
  localparam logic [1:0] TYPE_RF_RD   = 2'd1;
  localparam logic [1:0] TYPE_ALU_OP  = 2'd2;
  localparam logic [1:0] TYPE_ALU_NOP = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SEND    = 3'd1,
    ST_WAIT_HI = 3'd2,
    ST_WAIT_LO = 3'd3,
    ST_RECV    = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

  // Bytes sent per frame
  localparam logic [2:0] FRAME_LEN_RF_WR   = 3'd3;
  localparam logic [2:0] FRAME_LEN_RF_RD   = 3'd2;
  localparam logic [2:0] FRAME_LEN_ALU_OP  = 3'd4;
  localparam logic [2:0] FRAME_LEN_ALU_NOP = 3'd2;

  // Response bytes expected back
  localparam logic [1:0] RSP_LEN_RF_WR   = 2'd0;
  localparam logic [1:0] RSP_LEN_RF_RD   = 2'd1;
  localparam logic [1:0] RSP_LEN_ALU_OP  = 2'd2;
  localparam logic [1:0] RSP_LEN_ALU_NOP = 2'd2;

endpackage

// File: rtl/host_cmd_frame_builder.sv
// rtl/host_cmd_frame_builder.sv - combinational frame byte / length lookup
//
// Purpose: maps the latched command fields and the current byte index to the
// byte to transmit, plus the frame length and expected response byte count.
// Ports:
//   cmd_type_i  command type (TYPE_* encodings)
//   addr_i      register address, zero-extended into the frame
//   data_a_i    write data / operand A
//   data_b_i    operand B
//   fun_i       ALU function, placed in the low nibble
//   idx_i       index of the frame byte being requested
//   byte_o      frame byte at idx_i
//   frame_len_o number of bytes in the frame
//   rsp_len_o   number of response bytes to collect

module host_cmd_frame_builder
  import host_cmd_master_pkg::*;
#(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic [1:0]    cmd_type_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] data_a_i,
  input  logic [DW-1:0] data_b_i,
  input  logic [3:0]    fun_i,
  input  logic [1:0]    idx_i,
  output logic [DW-1:0] byte_o,
  output logic [2:0]    frame_len_o,
  output logic [1:0]    rsp_len_o
);

  logic [DW-1:0] addr_ext;
  logic [DW-1:0] fun_ext;

  assign addr_ext = DW'(addr_i);
  assign fun_ext  = DW'(fun_i);

  always_comb begin
    byte_o      = '0;
    frame_len_o = FRAME_LEN_RF_WR;
    rsp_len_o   = RSP_LEN_RF_WR;
    case (cmd_type_i)
      TYPE_RF_WR: begin
        frame_len_o = FRAME_LEN_RF_WR;
        rsp_len_o   = RSP_LEN_RF_WR;
        case (idx_i)
          2'd0:    byte_o = DW'(CMD_RF_WR);
          2'd1:    byte_o = addr_ext;
          2'd2:    byte_o = data_a_i;
          default: byte_o = '0;
        endcase
      end
      TYPE_RF_RD: begin
        frame_len_o = FRAME_LEN_RF_RD;
        rsp_len_o   = RSP_LEN_RF_RD;
        case (idx_i)
          2'd0:    byte_o = DW'(CMD_RF_RD);
          2'd1:    byte_o = addr_ext;
          default: byte_o = '0;
        endcase
      end
      TYPE_ALU_OP: begin
        frame_len_o = FRAME_LEN_ALU_OP;
        rsp_len_o   = RSP_LEN_ALU_OP;
        case (idx_i)
          2'd0:    byte_o = DW'(CMD_ALU_OP);
          2'd1:    byte_o = data_a_i;
          2'd2:    byte_o = data_b_i;
          default: byte_o = fun_ext;
        endcase
      end
      default: begin
        frame_len_o = FRAME_LEN_ALU_NOP;
        rsp_len_o   = RSP_LEN_ALU_NOP;
        case (idx_i)
          2'd0:    byte_o = DW'(CMD_ALU_NOP);
          2'd1:    byte_o = fun_ext;
          default: byte_o = '0;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/host_cmd_master.sv
// rtl/host_cmd_master.sv - UART command-protocol initiator with response assembly
//
// Purpose: accepts one command per CMD_VLD/CMD_RDY handshake, sends its frame
// byte by byte through a UART transmitter (TX_BUSY paced), collects the
// response bytes from a UART receiver and reports one result word.
// Ports:
//   CLK, RST                    clock, asynchronous active-high reset
//   CMD_VLD/CMD_RDY             command handshake
//   CMD_TYPE/ADDR/DATA_A/B/FUN  command fields, latched on accept
//   TX_DATA/TX_VLD/TX_BUSY      transmitter byte interface
//   RX_DATA/RX_VLD              receiver byte interface
//   RSP_DATA/RSP_VLD/RSP_ERR    result word, strobe, timeout flag

module host_cmd_master
  import host_cmd_master_pkg::*;
#(
  parameter int data_Width  = 8,
  parameter int Addr_width  = 4,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    CMD_VLD,
  output logic                    CMD_RDY,
  input  logic [1:0]              CMD_TYPE,
  input  logic [Addr_width-1:0]   CMD_ADDR,
  input  logic [data_Width-1:0]   CMD_DATA_A,
  input  logic [data_Width-1:0]   CMD_DATA_B,
  input  logic [3:0]              CMD_FUN,
  output logic [data_Width-1:0]   TX_DATA,
  output logic                    TX_VLD,
  input  logic                    TX_BUSY,
  input  logic [data_Width-1:0]   RX_DATA,
  input  logic                    RX_VLD,
  output logic [2*data_Width-1:0] RSP_DATA,
  output logic                    RSP_VLD,
  output logic                    RSP_ERR
);

  localparam int DW = data_Width;
  localparam int CW = $clog2(TIMEOUT_CYC);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYC - 1);

  state_e              state_q, state_d;
  logic [1:0]          type_q, type_d;
  logic [Addr_width-1:0] addr_q, addr_d;
  logic [DW-1:0]       a_q, a_d;
  logic [DW-1:0]       b_q, b_d;
  logic [3:0]          fun_q, fun_d;
  logic [2:0]          idx_q, idx_d;
  logic [1:0]          rx_cnt_q, rx_cnt_d;
  logic [2*DW-1:0]     rx_buf_q, rx_buf_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                err_q, err_d;
  logic                tx_vld_q, tx_vld_d;
  logic [DW-1:0]       tx_data_q, tx_data_d;
  logic [2*DW-1:0]     rsp_data_q, rsp_data_d;

  logic [DW-1:0]       frame_byte;
  logic [2:0]          frame_len;
  logic [1:0]          rsp_len;
  logic [2*DW-1:0]     rx_buf_nxt;
  logic [2:0]          idx_inc;
  logic                timeout;

  host_cmd_frame_builder #(
    .DW (DW),
    .AW (Addr_width)
  ) u_frame (
    .cmd_type_i  (type_q),
    .addr_i      (addr_q),
    .data_a_i    (a_q),
    .data_b_i    (b_q),
    .fun_i       (fun_q),
    .idx_i       (idx_q[1:0]),
    .byte_o      (frame_byte),
    .frame_len_o (frame_len),
    .rsp_len_o   (rsp_len)
  );

  assign CMD_RDY  = (state_q == ST_IDLE);
  assign TX_VLD   = tx_vld_q;
  assign TX_DATA  = tx_data_q;
  assign RSP_DATA = rsp_data_q;
  assign RSP_VLD  = (state_q == ST_DONE);
  assign RSP_ERR  = (state_q == ST_DONE) && err_q;

  assign timeout = (cnt_q == TO_LAST);
  assign idx_inc = idx_q + 3'd1;
  // Response bytes arrive LSB first
  assign rx_buf_nxt = (rx_cnt_q == 2'd0) ? {rx_buf_q[2*DW-1:DW], RX_DATA}
                                         : {RX_DATA, rx_buf_q[DW-1:0]};

  always_comb begin
    state_d    = state_q;
    type_d     = type_q;
    addr_d     = addr_q;
    a_d        = a_q;
    b_d        = b_q;
    fun_d      = fun_q;
    idx_d      = idx_q;
    rx_cnt_d   = rx_cnt_q;
    rx_buf_d   = rx_buf_q;
    err_d      = err_q;
    tx_vld_d   = 1'b0;
    tx_data_d  = tx_data_q;
    rsp_data_d = rsp_data_q;

    case (state_q)
      ST_IDLE: begin
        if (CMD_VLD) begin
          type_d   = CMD_TYPE;
          addr_d   = CMD_ADDR;
          a_d      = CMD_DATA_A;
          b_d      = CMD_DATA_B;
          fun_d    = CMD_FUN;
          idx_d    = 3'd0;
          rx_cnt_d = 2'd0;
          rx_buf_d = '0;
          err_d    = 1'b0;
          state_d  = ST_SEND;
        end
      end
      ST_SEND: begin
        if (!TX_BUSY) begin
          tx_vld_d  = 1'b1;
          tx_data_d = frame_byte;
          state_d   = ST_WAIT_HI;
        end else if (timeout) begin
          state_d = ST_DONE;
        end
      end
      ST_WAIT_HI: begin
        if (TX_BUSY) begin
          state_d = ST_WAIT_LO;
        end else if (timeout) begin
          state_d = ST_DONE;
        end
      end
      ST_WAIT_LO: begin
        if (!TX_BUSY) begin
          idx_d = idx_inc;
          if (idx_inc < frame_len) begin
            state_d = ST_SEND;
          end else if (rsp_len != 2'd0) begin
            state_d = ST_RECV;
          end else begin
            // Write commands report the cleared buffer, i.e. zero
            rsp_data_d = rx_buf_q;
            state_d    = ST_DONE;
          end
        end else if (timeout) begin
          state_d = ST_DONE;
        end
      end
      ST_RECV: begin
        if (RX_VLD) begin
          rx_buf_d = rx_buf_nxt;
          rx_cnt_d = rx_cnt_q + 2'd1;
          if ((rx_cnt_q + 2'd1) == rsp_len) begin
            rsp_data_d = rx_buf_nxt;
            state_d    = ST_DONE;
          end
        end else if (timeout) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A wait state entering DONE without its completing event is an abort
    if (state_d == ST_DONE && state_q != ST_DONE && timeout &&
        !(state_q == ST_RECV && RX_VLD) &&
        !(state_q == ST_WAIT_LO && !TX_BUSY)) begin
      err_d      = 1'b1;
      rsp_data_d = '0;
    end
  end

  // Progress watchdog: restarts on any state change or received byte,
  // saturates at its terminal value so it can never wrap back to zero.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q || RX_VLD) begin
      cnt_d = '0;
    end else if ((state_q == ST_SEND || state_q == ST_WAIT_HI ||
                  state_q == ST_WAIT_LO || state_q == ST_RECV) &&
                 cnt_q != TO_LAST) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      type_q     <= '0;
      addr_q     <= '0;
      a_q        <= '0;
      b_q        <= '0;
      fun_q      <= '0;
      idx_q      <= '0;
      rx_cnt_q   <= '0;
      rx_buf_q   <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      tx_vld_q   <= 1'b0;
      tx_data_q  <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      type_q     <= type_d;
      addr_q     <= addr_d;
      a_q        <= a_d;
      b_q        <= b_d;
      fun_q      <= fun_d;
      idx_q      <= idx_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_buf_q   <= rx_buf_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      tx_vld_q   <= tx_vld_d;
      tx_data_q  <= tx_data_d;
      rsp_data_q <= rsp_data_d;
    end
  end

endmodule

// File: tb/tb_host_cmd_master.sv
// tb/tb_host_cmd_master.sv - scoreboard bench for host_cmd_master

module tb_host_cmd_master;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int TO = 64;

  logic          CLK;
  logic          RST;
  logic          CMD_VLD;
  logic          CMD_RDY;
  logic [1:0]    CMD_TYPE;
  logic [AW-1:0] CMD_ADDR;
  logic [DW-1:0] CMD_DATA_A;
  logic [DW-1:0] CMD_DATA_B;
  logic [3:0]    CMD_FUN;
  logic [DW-1:0] TX_DATA;
  logic          TX_VLD;
  logic          TX_BUSY;
  logic [DW-1:0] RX_DATA;
  logic          RX_VLD;
  logic [15:0]   RSP_DATA;
  logic          RSP_VLD;
  logic          RSP_ERR;

  host_cmd_master #(
    .data_Width  (DW),
    .Addr_width  (AW),
    .TIMEOUT_CYC (TO)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .CMD_VLD    (CMD_VLD),
    .CMD_RDY    (CMD_RDY),
    .CMD_TYPE   (CMD_TYPE),
    .CMD_ADDR   (CMD_ADDR),
    .CMD_DATA_A (CMD_DATA_A),
    .CMD_DATA_B (CMD_DATA_B),
    .CMD_FUN    (CMD_FUN),
    .TX_DATA    (TX_DATA),
    .TX_VLD     (TX_VLD),
    .TX_BUSY    (TX_BUSY),
    .RX_DATA    (RX_DATA),
    .RX_VLD     (RX_VLD),
    .RSP_DATA   (RSP_DATA),
    .RSP_VLD    (RSP_VLD),
    .RSP_ERR    (RSP_ERR)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int tx_falls  = 0;
  int last_fall = 0;
  int busy_left = 0;
  int busy_len  = 10;
  int tx_seen   = 0;
  int rsp_seen  = 0;
  int rsp_cyc   = 0;

  logic [7:0]  exp_tx[$];
  logic [16:0] exp_rsp[$];   // {err, data}
  logic [7:0]  last_tx;
  logic [15:0] last_rsp;
  bit          prev_rsp;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial forever @(posedge CLK) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // UART transmitter model: goes busy as soon as a byte is strobed
  initial begin
    TX_BUSY = 1'b0;
    forever begin
      @(negedge CLK);
      if (RST) begin
        TX_BUSY   = 1'b0;
        busy_left = 0;
      end else if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) begin
          TX_BUSY   = 1'b0;
          tx_falls++;
          last_fall = cyc;
        end
      end else if (TX_VLD) begin
        TX_BUSY   = 1'b1;
        busy_left = busy_len;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a byte or result
  initial begin
    logic [7:0]  e;
    logic [16:0] r;
    forever begin
      @(negedge CLK);
      if (RST) begin
        last_tx  = 8'h00;
        last_rsp = 16'h0000;
        prev_rsp = 1'b0;
      end else begin
        if (prev_rsp) chk("rdy_after_rsp", CMD_RDY, 1);
        prev_rsp = RSP_VLD;
        if (TX_VLD) begin
          tx_seen++;
          if (exp_tx.size() == 0) begin
            total++;
            bad++;
            $display("FAIL tx_unexpected actual=%0h required=none", TX_DATA);
          end else begin
            e = exp_tx.pop_front();
            chk("tx_byte", TX_DATA, e);
          end
          last_tx = TX_DATA;
        end else begin
          chk("tx_hold", TX_DATA, last_tx);
        end
        if (RSP_VLD) begin
          chk("rdy_low_in_rsp", CMD_RDY, 0);
          if (exp_rsp.size() == 0) begin
            total++;
            bad++;
            $display("FAIL rsp_unexpected actual=%0h required=none", RSP_DATA);
          end else begin
            r = exp_rsp.pop_front();
            chk("rsp_data", RSP_DATA, r[15:0]);
            chk("rsp_err", RSP_ERR, r[16]);
          end
          last_rsp = RSP_DATA;
          rsp_cyc  = cyc;
          rsp_seen++;
        end else begin
          chk("rsp_hold", RSP_DATA, last_rsp);
        end
      end
    end
  end

  task automatic handshake(input logic [1:0] t, input logic [3:0] ad,
                           input logic [7:0] a, input logic [7:0] b, input logic [3:0] f);
    int k;
    k = 0;
    @(negedge CLK);
    while (!CMD_RDY && k < 500) begin
      @(negedge CLK);
      k++;
    end
    if (!CMD_RDY) begin
      total++;
      bad++;
      $display("FAIL cmd_rdy_wait actual=%0d required=1", CMD_RDY);
    end
    CMD_TYPE   = t;
    CMD_ADDR   = ad;
    CMD_DATA_A = a;
    CMD_DATA_B = b;
    CMD_FUN    = f;
    CMD_VLD    = 1'b1;
    @(negedge CLK);
    CMD_VLD    = 1'b0;
    chk("rdy_drop", CMD_RDY, 0);
    // Fields must have been latched; scramble them
    CMD_TYPE   = 2'($urandom);
    CMD_ADDR   = 4'($urandom);
    CMD_DATA_A = 8'($urandom);
    CMD_DATA_B = 8'($urandom);
    CMD_FUN    = 4'($urandom);
  endtask

  task automatic run_cmd(input logic [1:0] t, input logic [3:0] ad,
                         input logic [7:0] a, input logic [7:0] b, input logic [3:0] f,
                         input logic [7:0] r0, input logic [7:0] r1,
                         input bit stray, input bit no_rx);
    int n, nrx, base_f, base_r, last_ev, k;
    logic [15:0] ed;
    base_f = tx_falls;
    base_r = rsp_seen;
    case (t)
      2'd0: begin
        exp_tx.push_back(8'hAA); exp_tx.push_back({4'h0, ad}); exp_tx.push_back(a);
        n = 3; nrx = 0; ed = 16'h0000;
      end
      2'd1: begin
        exp_tx.push_back(8'hBB); exp_tx.push_back({4'h0, ad});
        n = 2; nrx = 1; ed = {8'h00, r0};
      end
      2'd2: begin
        exp_tx.push_back(8'hCC); exp_tx.push_back(a); exp_tx.push_back(b);
        exp_tx.push_back({4'h0, f});
        n = 4; nrx = 2; ed = {r1, r0};
      end
      default: begin
        exp_tx.push_back(8'hDD); exp_tx.push_back({4'h0, f});
        n = 2; nrx = 2; ed = {r1, r0};
      end
    endcase
    if (no_rx) exp_rsp.push_back({1'b1, 16'h0000});
    else       exp_rsp.push_back({1'b0, ed});

    handshake(t, ad, a, b, f);

    if (stray) begin
      k = 0;
      while (!TX_VLD && k < 100) begin
        @(negedge CLK);
        k++;
      end
      RX_DATA = 8'hAB;
      RX_VLD  = 1'b1;
      @(negedge CLK);
      RX_VLD  = 1'b0;
    end

    k = 0;
    while (tx_falls < base_f + n && k < 3000) begin
      @(negedge CLK);
      k++;
    end
    if (tx_falls < base_f + n) begin
      total++;
      bad++;
      $display("FAIL tx_frame_wait actual=%0d required=%0d", tx_falls - base_f, n);
      exp_tx.delete();
      exp_rsp.delete();
      return;
    end
    last_ev = last_fall;

    if (!no_rx) begin
      for (int i = 0; i < nrx; i++) begin
        repeat ($urandom_range(1, 6)) @(negedge CLK);
        RX_DATA = (i == 0) ? r0 : r1;
        RX_VLD  = 1'b1;
        last_ev = cyc;
        @(negedge CLK);
        RX_VLD  = 1'b0;
        RX_DATA = 8'($urandom);
      end
    end

    k = 0;
    while (rsp_seen == base_r && k < 300) begin
      @(negedge CLK);
      k++;
    end
    if (rsp_seen == base_r) begin
      total++;
      bad++;
      $display("FAIL rsp_wait actual=none required=response");
      exp_rsp.delete();
      return;
    end
    chk("rsp_latency", rsp_cyc - last_ev, no_rx ? TO + 1 : 1);
  endtask

  task automatic reset_mid_frame();
    int k, base_t, base_r;
    base_t = tx_seen;
    exp_tx.push_back(8'hCC); exp_tx.push_back(8'h5A); exp_tx.push_back(8'hA5);
    exp_tx.push_back(8'h07);
    handshake(2'd2, 4'h0, 8'h5A, 8'hA5, 4'h7);
    k = 0;
    while (tx_seen < base_t + 2 && k < 500) begin
      @(negedge CLK);
      k++;
    end
    chk("rst_two_bytes_sent", tx_seen - base_t, 2);
    @(negedge CLK);
    RST = 1'b1;
    #1;
    exp_tx.delete();
    base_r = rsp_seen;
    chk("rst_cmd_rdy", CMD_RDY, 1);
    chk("rst_tx_vld", TX_VLD, 0);
    chk("rst_tx_data", TX_DATA, 0);
    chk("rst_rsp_vld", RSP_VLD, 0);
    chk("rst_rsp_err", RSP_ERR, 0);
    chk("rst_rsp_data", RSP_DATA, 0);
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    repeat (20) @(negedge CLK);
    chk("rst_no_rsp", rsp_seen - base_r, 0);
    chk("rst_no_tx", tx_seen - base_t, 2);
  endtask

  initial begin
    RST        = 1'b1;
    CMD_VLD    = 1'b0;
    CMD_TYPE   = 2'd0;
    CMD_ADDR   = '0;
    CMD_DATA_A = '0;
    CMD_DATA_B = '0;
    CMD_FUN    = '0;
    RX_DATA    = '0;
    RX_VLD     = 1'b0;
    repeat (3) @(negedge CLK);
    chk("reset_cmd_rdy", CMD_RDY, 1);
    chk("reset_tx_vld", TX_VLD, 0);
    chk("reset_tx_data", TX_DATA, 0);
    chk("reset_rsp_vld", RSP_VLD, 0);
    chk("reset_rsp_err", RSP_ERR, 0);
    chk("reset_rsp_data", RSP_DATA, 0);
    RST = 1'b0;

    busy_len = 10;
    run_cmd(2'd0, 4'h5, 8'h3C, 8'h00, 4'h0, 8'h00, 8'h00, 1'b0, 1'b0);
    run_cmd(2'd1, 4'h2, 8'h00, 8'h00, 4'h0, 8'h7E, 8'h00, 1'b0, 1'b0);
    run_cmd(2'd2, 4'h0, 8'h12, 8'h34, 4'h1, 8'h46, 8'h00, 1'b0, 1'b0);
    run_cmd(2'd3, 4'h0, 8'h00, 8'h00, 4'h2, 8'hD8, 8'h01, 1'b1, 1'b0);
    run_cmd(2'd1, 4'h3, 8'h00, 8'h00, 4'h0, 8'h00, 8'h00, 1'b0, 1'b1);
    reset_mid_frame();
    run_cmd(2'd1, 4'h9, 8'h00, 8'h00, 4'h0, 8'hC3, 8'h00, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      busy_len = $urandom_range(1, 12);
      run_cmd(2'($urandom), 4'($urandom), 8'($urandom), 8'($urandom), 4'($urandom),
              8'($urandom), 8'($urandom), ($urandom_range(0, 3) == 0), 1'b0);
    end

    repeat (5) @(negedge CLK);
    chk("tx_queue_empty", exp_tx.size(), 0);
    chk("rsp_queue_empty", exp_rsp.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
